vc_local_arbiter: RTL and testbench
===================================

VC_LOCAL_ARBITER -- requirements
Module: vc_local_arbiter

Interface
REQ-001 Parameter: V, 4, number of VCs per input port; only V=4 is supported.
REQ-002 Parameter: TMO, 16, watchdog limit in cycles; range 2..255; used only with VC_ARB_TIMEOUT_EN.
REQ-003 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset; synchronous and active-high.
REQ-005 Port: req  in  V  per-VC flit-pending flag, bit i = VC i has a flit at its head.
REQ-006 Port: tail  in  V  per-VC flag, bit i = the head flit of VC i is a tail flit.
REQ-007 Port: gnt_main  in  1  main allocator accepts this port's flit this cycle.
REQ-008 Port: sel  out  V  one-hot VC select to the input-port mux; all zero when no VC is selected.
REQ-009 Port: req_out  out  1  request to the main allocator on behalf of the port.
REQ-010 Port: pop  out  V  one-hot dequeue pulse to the winning VC.
REQ-011 Port: busy  out  1  high while the arbiter is in LOCKED.

Function
REQ-012 The FSM shall have two states: IDLE and LOCKED.
REQ-013 In IDLE: sel=0, req_out=0, pop=0, busy=0.
REQ-014 In IDLE, if req != 0, the FSM shall choose the first set req bit at or after ptr, wrapping modulo V (round-robin); sel shall load that one-hot value; the FSM shall enter LOCKED on the next edge.
REQ-015 In LOCKED: busy=1; req_out = |(req & sel); sel shall hold until packet release.
REQ-016 pop = sel when gnt_main=1 and req_out=1; otherwise pop=0. pop is combinational, 0-cycle latency.
REQ-017 If gnt_main=1 and req_out=1 in LOCKED, and the selected VC's tail bit is 1: return to IDLE, clear sel, and set ptr to (winner index + 1) mod V.
REQ-018 If gnt_main=1 while req_out=0, the FSM shall ignore it: no pop and no state change.
REQ-019 Changes on non-selected req bits while in LOCKED shall have no effect. A packet is never interleaved with another VC.
REQ-020 Packet release costs a 1-cycle IDLE bubble; the next grant decision occurs in that IDLE cycle.
REQ-021 A single-flit packet (head = tail) shall be granted and released in one LOCKED cycle.
REQ-022 ptr is a log2(V)-bit counter; wrap from V-1 to 0 is required.

Reset
REQ-023 While rst=1 at a clock edge, the following shall be cleared: state=IDLE, sel=0, ptr=0, watchdog counter=0.
REQ-024 While rst=1, all outputs shall read 0.
REQ-025 Reset asserted mid-packet shall abandon the lock; no pop shall be issued in that cycle.

Configuration
REQ-026 Macro VC_ARB_TIMEOUT_EN shall compile in an 8-bit watchdog counter.
REQ-027 With VC_ARB_TIMEOUT_EN defined:
- In LOCKED, the counter increments on each cycle with req_out=0.
- It clears on any cycle with req_out=1, and on entry to LOCKED.
- When the counter reaches TMO, the FSM shall return to IDLE with ptr = winner + 1, without a pop.
REQ-028 Without VC_ARB_TIMEOUT_EN, no counter shall exist, and LOCKED shall be left only via a tail grant or reset.

Verification
REQ-029 Reset, then req=4'b0000 for 10 cycles -> sel=0, req_out=0, busy=0 throughout.
REQ-030 After reset, req=4'b1010; on each LOCKED cycle gnt_main=1; tail bit goes high on the 3rd flit:
- sel=4'b0010 from cycle 2;
- pop[1] pulses 3 times;
- IDLE one cycle;
- then sel=4'b1000 (ptr was 2).
REQ-031 All req=1, every flit a tail, gnt_main=1 constantly -> sel sequence 0001,0010,0100,1000,0001, each separated by one IDLE cycle.
REQ-032 Locked on VC2; mid-packet, req[2] drops for 5 cycles while gnt_main=1 -> req_out=0 and no pop during those cycles; sel stays 4'b0100.
REQ-033 rst=1 asserted while locked on VC3 mid-packet -> next cycle IDLE, sel=0, ptr=0; the next arbitration starts from VC0.
REQ-034 With VC_ARB_TIMEOUT_EN and TMO=16: locked on VC0, req[0]=0 for 16 cycles -> IDLE on cycle 16 with no pop; the following winner is searched from VC1.

Source files
------------

// File: rtl/vc_local_arbiter_if.sv
// Handshake bundle between an input port's VC buffers, the local VC arbiter
// and the main switch allocator.
interface vc_local_arbiter_if #(
  parameter int V = 4
);
  logic [V-1:0] req;
  logic [V-1:0] tail;
  logic         gnt_main;
  logic [V-1:0] sel;
  logic         req_out;
  logic [V-1:0] pop;
  logic         busy;

  modport master (
    output req, tail, gnt_main,
    input  sel, req_out, pop, busy
  );

  modport slave (
    input  req, tail, gnt_main,
    output sel, req_out, pop, busy
  );
endinterface

// File: rtl/vc_local_arbiter.sv
// Per-input-port VC arbiter: round-robin pick, packet lock until tail grant.
// Optional watchdog release when compiled with `define VC_ARB_TIMEOUT_EN.
module vc_local_arbiter #(
  parameter int V   = 4,
  parameter int TMO = 16
) (
  input logic               clk,
  input logic               rst,
  vc_local_arbiter_if.slave bus
);
  localparam int PW = $clog2(V);

  if (V != 4 || TMO < 2 || TMO > 255) begin : g_bad_cfg
    $error("vc_local_arbiter: unsupported V or TMO");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state;
  logic [V-1:0]  sel_lock;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic          busy_q;

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic [V-1:0]  pick_onehot;
  logic          req_hit;
  logic          tail_hit;
  logic          grant;
  logic          wd_expire;
  logic          release_now;

`ifdef VC_ARB_TIMEOUT_EN
  logic [7:0]    wd;
`endif

  // Lowest rotation offset from p wins; index arithmetic wraps because V is a power of two.
  function automatic logic [PW:0] rr_pick(input logic [V-1:0] r, input logic [PW-1:0] p);
    logic [PW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = V - 1; i >= 0; i--) begin
      idx = p + PW'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    {pick_vld, pick_idx} = rr_pick(bus.req, ptr);
    pick_onehot = {{(V-1){1'b0}}, 1'b1} << pick_idx;
    req_hit     = |(bus.req & sel_lock);
    tail_hit    = |(bus.tail & sel_lock);
    grant       = !rst && (state == LOCKED) && req_hit && bus.gnt_main;
`ifdef VC_ARB_TIMEOUT_EN
    wd_expire   = (state == LOCKED) && !req_hit && (wd == 8'(TMO - 1));
`else
    wd_expire   = 1'b0;
`endif
    release_now = (grant && tail_hit) || wd_expire;
  end

  // Outputs are forced low during reset so a mid-packet reset never pops.
  assign bus.sel     = rst ? '0 : sel_lock;
  assign bus.req_out = !rst && (state == LOCKED) && req_hit;
  assign bus.pop     = grant ? sel_lock : '0;
  assign bus.busy    = !rst && busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_lock <= '0;
      ptr      <= '0;
      win_idx  <= '0;
      busy_q   <= 1'b0;
`ifdef VC_ARB_TIMEOUT_EN
      wd       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= LOCKED;
            sel_lock <= pick_onehot;
            win_idx  <= pick_idx;
            busy_q   <= 1'b1;
          end
`ifdef VC_ARB_TIMEOUT_EN
          wd <= '0;
`endif
        end
        LOCKED: begin
          if (release_now) begin
            state    <= IDLE;
            sel_lock <= '0;
            busy_q   <= 1'b0;
            ptr      <= win_idx + 1'b1;
          end
`ifdef VC_ARB_TIMEOUT_EN
          if (req_hit || release_now) wd <= '0;
          else                        wd <= wd + 8'd1;
`endif
        end
        default: begin
          state    <= IDLE;
          sel_lock <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vc_local_arbiter.sv
// Directed bench for vc_local_arbiter; the watchdog section runs only when
// compiled with VC_ARB_TIMEOUT_EN.
module tb_vc_local_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vc_local_arbiter_if #(.V(4)) bus ();

  vc_local_arbiter #(.V(4), .TMO(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-low-phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] s, input logic r,
                         input logic [3:0] p, input logic b);
    chk({tag, "_sel"},     {4'h0, bus.sel}, {4'h0, s});
    chk({tag, "_req_out"}, {7'h0, bus.req_out}, {7'h0, r});
    chk({tag, "_pop"},     {4'h0, bus.pop}, {4'h0, p});
    chk({tag, "_busy"},    {7'h0, bus.busy}, {7'h0, b});
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.tail = 4'b1111;
    bus.gnt_main = 1'b1;
    @(negedge clk);
    tick();
    settle();
    chk_all("rst_hold", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Idle with no requests
    rst = 1'b0;
    bus.req = 4'b0000;
    bus.tail = 4'b0000;
    bus.gnt_main = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      settle();
      chk_all("idle_noreq", 4'b0000, 1'b0, 4'b0000, 1'b0);
    end

    // Three-flit packet on VC1, then VC3 from ptr=2
    bus.req = 4'b1010;
    bus.gnt_main = 1'b1;
    settle();
    chk_all("pkt_idle", 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick();
    settle();
    chk_all("pkt_flit1", 4'b0010, 1'b1, 4'b0010, 1'b1);
    tick();
    settle();
    chk_all("pkt_flit2", 4'b0010, 1'b1, 4'b0010, 1'b1);
    tick();
    bus.tail = 4'b0010;
    settle();
    chk_all("pkt_flit3", 4'b0010, 1'b1, 4'b0010, 1'b1);
    tick();
    settle();
    chk_all("pkt_bubble", 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick();
    bus.tail = 4'b1000;
    settle();
    chk_all("pkt_next_vc3", 4'b1000, 1'b1, 4'b1000, 1'b1);
    tick();
    settle();
    chk_all("pkt_vc3_rel", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Single-flit packets on every VC: full rotation with wrap
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;
    bus.req = 4'b1111;
    bus.tail = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      settle();
      chk_all("rr_lock", rr_exp[i], 1'b1, rr_exp[i], 1'b1);
      tick();
      settle();
      chk_all("rr_bubble", 4'b0000, 1'b0, 4'b0000, 1'b0);
    end

    // VC2 lock; selected req drops while others toggle and grant is held
    bus.req = 4'b0100;
    bus.tail = 4'b0000;
    bus.gnt_main = 1'b0;
    tick();
    settle();
    chk_all("vc2_nogrant", 4'b0100, 1'b1, 4'b0000, 1'b1);
    bus.gnt_main = 1'b1;
    settle();
    chk_all("vc2_grant", 4'b0100, 1'b1, 4'b0100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.req = (i % 2 == 0) ? 4'b1011 : 4'b0000;
      bus.tail = 4'b1011;
      settle();
      chk_all("vc2_stall", 4'b0100, 1'b0, 4'b0000, 1'b1);
    end
    tick();
    bus.req = 4'b0100;
    bus.tail = 4'b0100;
    settle();
    chk_all("vc2_tail", 4'b0100, 1'b1, 4'b0100, 1'b1);
    tick();
    settle();
    chk_all("vc2_rel", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // VC3 lock, reset mid-packet, arbitration restarts at VC0
    bus.req = 4'b1000;
    bus.tail = 4'b0000;
    tick();
    settle();
    chk_all("vc3_lock", 4'b1000, 1'b1, 4'b1000, 1'b1);
    tick();
    rst = 1'b1;
    settle();
    chk_all("vc3_rst", 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick();
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.gnt_main = 1'b0;
    settle();
    chk_all("post_rst_idle", 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick();
    settle();
    chk_all("post_rst_vc0", 4'b0001, 1'b1, 4'b0000, 1'b1);

`ifdef VC_ARB_TIMEOUT_EN
    // Stalled VC0 released by the watchdog; next search starts at VC1
    bus.req = 4'b0000;
    bus.gnt_main = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      settle();
      chk_all("wd_stall", (i == 15) ? 4'b0000 : 4'b0001, 1'b0, 4'b0000, (i == 15) ? 1'b0 : 1'b1);
    end
    bus.req = 4'b1111;
    tick();
    settle();
    chk_all("wd_next_vc1", 4'b0010, 1'b1, 4'b0010, 1'b1);
`else
    // Without the watchdog a stalled lock persists indefinitely
    bus.req = 4'b0000;
    bus.gnt_main = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    settle();
    chk_all("no_wd_hold", 4'b0001, 1'b0, 4'b0000, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
